// File: rtl/gomoku_game_ctrl_if.sv
// Command pulses into, and registered game state out of, the gomoku controller.
// The master side issues commands; the slave side is the controller.
interface gomoku_game_ctrl_if;
  logic         mv_up;
  logic         mv_down;
  logic         mv_left;
  logic         mv_right;
  logic         place;
  logic         restart;
  logic [511:0] board;
  logic [1:0]   gaming_status;
  logic [3:0]   pointer_loc_x;
  logic [3:0]   pointer_loc_y;
  logic         turn;
  logic         busy;
  logic [8:0]   stone_count;

  modport master (
    output mv_up, mv_down, mv_left, mv_right, place, restart,
    input  board, gaming_status, pointer_loc_x, pointer_loc_y, turn, busy, stone_count
  );

  modport slave (
    input  mv_up, mv_down, mv_left, mv_right, place, restart,
    output board, gaming_status, pointer_loc_x, pointer_loc_y, turn, busy, stone_count
  );
endinterface

// File: rtl/gomoku_game_ctrl.sv
// Gomoku game-state controller: 16x16 board, turn and cursor registers, plus a
// fixed 32-cycle five-in-a-row check (one probe per cycle) after each placement.
module gomoku_game_ctrl #(
  parameter logic [3:0] PTR_X0 = 4'd4,
  parameter logic [3:0] PTR_Y0 = 4'd6
) (
  input logic               Clck,
  input logic               Reset,
  gomoku_game_ctrl_if.slave gif
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESOLVE} state_t;

  state_t       state_q, state_d;
  logic [511:0] board_q, board_d;
  logic [1:0]   status_q, status_d;
  logic [3:0]   px_q, px_d, py_q, py_d;
  logic         turn_q, turn_d, busy_q, busy_d;
  logic [8:0]   count_q, count_d;
  logic [3:0]   lx_q, lx_d, ly_q, ly_d;
  logic [1:0]   colour_q, colour_d;
  logic [4:0]   step_q, step_d;
  logic         alive_q, alive_d, win_q, win_d;
  logic [3:0]   run_q, run_d;

  logic         restart_go;
  logic [2:0]   off;
  logic         x_mv, y_mv, x_pos, y_pos;
  logic [5:0]   probe_x, probe_y;
  logic         alive_eff, hit;
  logic [3:0]   run_n;

  assign restart_go = (state_q == S_IDLE) && gif.restart;

  // step = {direction[1:0], negative half, offset-1}; out-of-range probes land in bits [5:4]
  always_comb begin
    off     = {1'b0, step_q[1:0]} + 3'd1;
    x_mv    = step_q[4:3] != 2'd1;
    y_mv    = step_q[4:3] != 2'd0;
    x_pos   = !step_q[2];
    y_pos   = (step_q[4:3] == 2'd3) ? step_q[2] : !step_q[2];
    probe_x = {2'b00, lx_q};
    probe_y = {2'b00, ly_q};
    if (x_mv) probe_x = x_pos ? probe_x + {3'b000, off} : probe_x - {3'b000, off};
    if (y_mv) probe_y = y_pos ? probe_y + {3'b000, off} : probe_y - {3'b000, off};
    alive_eff = (step_q[1:0] == 2'd0) || alive_q;
    hit       = alive_eff && (probe_x[5:4] == 2'b00) && (probe_y[5:4] == 2'b00) &&
                (board_q[{probe_y[3:0], probe_x[3:0], 1'b0} +: 2] == colour_q);
    run_n     = ((step_q[2:0] == 3'd0) ? 4'd1 : run_q) + {3'b000, hit};
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    status_d = status_q;
    px_d     = px_q;
    py_d     = py_q;
    turn_d   = turn_q;
    busy_d   = busy_q;
    count_d  = count_q;
    lx_d     = lx_q;
    ly_d     = ly_q;
    colour_d = colour_q;
    step_d   = step_q;
    alive_d  = alive_q;
    win_d    = win_q;
    run_d    = run_q;
    case (state_q)
      S_IDLE: begin
        if (gif.place && status_q == 2'b10 && board_q[{py_q, px_q, 1'b0} +: 2] == 2'b11) begin
          colour_d = turn_q ? 2'b10 : 2'b01;
          board_d[{py_q, px_q, 1'b0} +: 2] = colour_d;
          count_d  = count_q + 9'd1;
          lx_d     = px_q;
          ly_d     = py_q;
          step_d   = 5'd0;
          win_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_CHECK;
        end else begin
          // down grows y, matching screen coordinates
          px_d = px_q + {3'b000, gif.mv_right & ~gif.mv_left} - {3'b000, gif.mv_left & ~gif.mv_right};
          py_d = py_q + {3'b000, gif.mv_down & ~gif.mv_up} - {3'b000, gif.mv_up & ~gif.mv_down};
        end
      end
      S_CHECK: begin
        step_d  = step_q + 5'd1;
        alive_d = hit;
        run_d   = run_n;
        win_d   = win_q || (run_n >= 4'd5);
        if (step_q == 5'd31) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (win_q)                 status_d = (colour_q == 2'b01) ? 2'b01 : 2'b11;
        else if (count_q == 9'd256) status_d = 2'b00;
        else                       turn_d = ~turn_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clck) begin
    if (Reset || restart_go) begin
      state_q  <= S_IDLE;
      board_q  <= '1;
      status_q <= 2'b10;
      px_q     <= PTR_X0;
      py_q     <= PTR_Y0;
      turn_q   <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 9'd0;
      lx_q     <= 4'd0;
      ly_q     <= 4'd0;
      colour_q <= 2'b00;
      step_q   <= 5'd0;
      alive_q  <= 1'b0;
      win_q    <= 1'b0;
      run_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      status_q <= status_d;
      px_q     <= px_d;
      py_q     <= py_d;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      colour_q <= colour_d;
      step_q   <= step_d;
      alive_q  <= alive_d;
      win_q    <= win_d;
      run_q    <= run_d;
    end
  end

  assign gif.board         = board_q;
  assign gif.gaming_status = status_q;
  assign gif.pointer_loc_x = px_q;
  assign gif.pointer_loc_y = py_q;
  assign gif.turn          = turn_q;
  assign gif.busy          = busy_q;
  assign gif.stone_count   = count_q;
endmodule

// File: doc/gomoku_game_ctrl.md
# gomoku_game_ctrl

Game-state controller for the FiveSons five-in-a-row game on a 16×16 board. It sits directly upstream of the VGA renderer and drives that renderer's `board`, `gaming_status`, `pointer_loc_x` and `pointer_loc_y` inputs. It accepts one-cycle command pulses (cursor moves, place stone, restart), maintains the packed board and turn, and runs a fixed-latency five-in-a-row check after every placement.

## Interface
- `PTR_X0`, default 4: pointer x after reset or restart.
- `PTR_Y0`, default 6: pointer y after reset or restart.
- `Clck`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  single-cycle, already-debounced cursor pulses.
- `place`  in  1  single-cycle pulse: place the current player's stone at the pointer.
- `restart`  in  1  single-cycle pulse: start a new game.
- `board`  out  512  cell (x,y) occupies bits [x*2 + y*32 +: 2]. Encoding: 2'b11 empty, 2'b01 player 1, 2'b10 player 2.
- `gaming_status`  out  2  2'b10 in play, 2'b01 player 1 won, 2'b11 player 2 won, 2'b00 draw.
- `pointer_loc_x`, `pointer_loc_y`  out  4 each  cursor cell.
- `turn`  out  1  0 = player 1 to move, 1 = player 2 to move.
- `busy`  out  1  high while a win check is running.
- `stone_count`  out  9  number of stones on the board, 0..256.

## Operation
- Reset and restart produce the same state: board all ones, `gaming_status` = 2'b10, pointer = (`PTR_X0`, `PTR_Y0`), `turn` = 0, `busy` = 0, `stone_count` = 0, FSM in IDLE.
- FSM states: IDLE, CHECK, RESOLVE.
- IDLE, per command:
  - `restart`: top priority; it is ignored only while `busy` is high.
  - `place`: accepted only when `gaming_status` = 2'b10 and the cell at the pointer is 2'b11. Writes 2'b01 (turn 0) or 2'b10 (turn 1), increments `stone_count`, latches the placed coordinate and colour, then goes to CHECK. Moves in the same cycle are dropped. A `place` on an occupied cell, or after the game is over, is a no-op.
  - Moves: x and y wrap modulo 16 (15+1 → 0, 0−1 → 15). Left and right together cancel, as do up and down together. Moves are still accepted after the game is over.
- CHECK runs exactly 32 cycles, one probe per cycle, in this order:
  - Directions: horizontal (+x then −x), vertical (+y then −y), diagonal (+x+y then −x−y), anti-diagonal (+x−y then −x+y).
  - Each half-direction probes offsets 1 to 4.
  - A probe counts only if its coordinate is on the board, the cell holds the latched colour, and no earlier probe in the same half-direction failed. Off-board coordinates fail; there is no wrap.
  - Per-direction run = 1 + counted probes, held in a 4-bit counter.
  - A direction with run ≥ 5 sets a sticky win flag. Overlines (run > 5) count as wins.
- RESOLVE, one cycle:
  - Win flag set: `gaming_status` = 2'b01 or 2'b11 according to the latched colour; `turn` does not change.
  - Else, if `stone_count` = 256: status = 2'b00.
  - Else: `turn` toggles.
  - In every case, return to IDLE.
- All commands, including `restart`, are ignored while in CHECK or RESOLVE.
- `Reset` overrides everything in every state, including mid-CHECK.

## Timing
- Cursor move accepted at edge N: the pointer outputs change at edge N.
- `place` accepted at edge N:
  - At edge N: `board` and `stone_count` update, `busy` rises.
  - Edges N+1 to N+32: CHECK probes.
  - Edge N+33: RESOLVE updates `gaming_status` and `turn`, and `busy` falls.
  - The first new command is accepted at edge N+34.
- Restart takes effect at the accepting edge.
- All outputs are registered.

## Test plan
- Pointer: after reset, pointer = (4,6). Six `mv_right` pulses → x = 10. Eleven more `mv_right` pulses → x = 5 (wrap through 15 → 0). `mv_up` and `mv_down` in the same cycle → y unchanged.
- Placement and turns: `place` at (4,6) → bits [200:201] = 2'b01, `busy` high for exactly 33 cycles, `turn` = 1, `stone_count` = 1. A second `place` at the same cell → board, turn and count unchanged.
- Horizontal win: player 1 at (0..3,0) and player 2 at (0..3,5), alternating; then player 1 at (4,0) → `gaming_status` = 2'b01 at accept+33. Further `place` pulses are ignored; moves still work.
- Edge and diagonal: player 2 wins on the anti-diagonal (15,0),(14,1),(13,2),(12,3),(11,4) → status 2'b11. Four-in-a-row touching the board edge with no fifth stone → status stays 2'b10 (no wrap).
- Draw: fill all 256 cells with a no-five pattern → after the last RESOLVE, status = 2'b00 and `stone_count` = 256.
- Mid-check reset and ignored restart: assert `Reset` 10 cycles into CHECK → all outputs return to reset values on the next edge. `restart` pulsed during CHECK → no effect.
